// File: rtl/svc_rv_trace_pkg.sv
// Shared types for the RVFI retire-trace capture stage: the captured record,
// serializer states and the meta-beat bit layout.
package svc_rv_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic        trap;
        logic        drop;
        logic [4:0]  rd;
        logic [24:0] order25;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_BEAT2 = 3'd3,
        ST_BEAT3 = 3'd4
    } trace_state_t;

    localparam int META_TRAP_BIT  = 31;
    localparam int META_DROP_BIT  = 30;
    localparam int META_RD_LSB    = 25;
    localparam int META_ORDER_LSB = 0;

    function automatic logic [31:0] meta_word(input trace_rec_t r);
        logic [31:0] m;
        m = '0;
        m[META_TRAP_BIT]           = r.trap;
        m[META_DROP_BIT]           = r.drop;
        m[META_RD_LSB +: 5]        = r.rd;
        m[META_ORDER_LSB +: 25]    = r.order25;
        return m;
    endfunction

endpackage

// File: rtl/svc_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Also exposes the entry behind the
// head so a consumer can preload the next record in the same cycle it pops.
module svc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH-1:0]         rd_data_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign rd_data      = mem[rd_ptr];
    assign rd_data_next = mem[rd_ptr_nx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/svc_rv_trace.sv
// Retire-trace capture: snapshots RVFI retirements into a record FIFO and
// streams each record as four 32-bit beats; overflow records are dropped and counted.
//
// state | meaning
// IDLE  | no record presented, m_valid low
// BEAT0 | presenting pc
// BEAT1 | presenting insn
// BEAT2 | presenting rd write data
// BEAT3 | presenting meta word, m_last high; handshake pops the record
module svc_rv_trace
    import svc_rv_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          rvfi_valid,
    input  logic [63:0]   rvfi_order,
    input  logic [31:0]   rvfi_pc_rdata,
    input  logic [31:0]   rvfi_insn,
    input  logic [4:0]    rvfi_rd_addr,
    input  logic [31:0]   rvfi_rd_wdata,
    input  logic          rvfi_trap,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_last,
    input  logic          clr_drops,
    output logic [CW-1:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $bits(trace_rec_t);

    trace_state_t     state;
    trace_rec_t       in_rec;
    trace_rec_t       head;
    trace_rec_t       head_next;
    trace_rec_t       next_rec;
    logic [RW-1:0]    fifo_rd;
    logic [RW-1:0]    fifo_rd_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             capture;
    logic             push;
    logic             drop;
    logic             pop;
    logic             more;
    logic             drop_pending;
    logic             order_unused;

    assign capture = en && rvfi_valid;
    assign push    = capture && !fifo_full;
    assign drop    = capture && fifo_full;
    assign pop     = m_valid && m_ready && (state == ST_BEAT3);

    assign order_unused = ^rvfi_order[63:25];

    always_comb begin
        in_rec         = '0;
        in_rec.pc      = rvfi_pc_rdata;
        in_rec.insn    = rvfi_insn;
        in_rec.wdata   = rvfi_rd_wdata;
        in_rec.trap    = rvfi_trap;
        in_rec.drop    = drop_pending;
        in_rec.rd      = rvfi_rd_addr;
        in_rec.order25 = rvfi_order[24:0];
    end

    assign head      = trace_rec_t'(fifo_rd);
    assign head_next = trace_rec_t'(fifo_rd_next);

    // After popping a single-entry FIFO, the only follow-on record is the one being pushed now.
    assign more     = (fifo_count > (AW+1)'(1)) || push;
    assign next_rec = (fifo_count > (AW+1)'(1)) ? head_next : in_rec;

    svc_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .wr_data      (in_rec),
        .pop          (pop),
        .rd_data      (fifo_rd),
        .rd_data_next (fifo_rd_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pending <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (drop)      drop_pending <= 1'b1;
            else if (push) drop_pending <= 1'b0;

            if (drop) begin
                if (clr_drops)        drop_count <= CW'(1);
                else if (!(&drop_count)) drop_count <= drop_count + CW'(1);
            end else if (clr_drops) begin
                drop_count <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_BEAT0;
                        m_valid <= 1'b1;
                        m_data  <= head.pc;
                        m_last  <= 1'b0;
                    end
                end
                ST_BEAT0: begin
                    if (m_ready) begin
                        state  <= ST_BEAT1;
                        m_data <= head.insn;
                    end
                end
                ST_BEAT1: begin
                    if (m_ready) begin
                        state  <= ST_BEAT2;
                        m_data <= head.wdata;
                    end
                end
                ST_BEAT2: begin
                    if (m_ready) begin
                        state  <= ST_BEAT3;
                        m_data <= meta_word(head);
                        m_last <= 1'b1;
                    end
                end
                ST_BEAT3: begin
                    if (m_ready) begin
                        m_last <= 1'b0;
                        if (more) begin
                            state  <= ST_BEAT0;
                            m_data <= next_rec.pc;
                        end else begin
                            state   <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_data  <= '0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
